// File: rtl/status_register.sv
// Two-bit compare status register (NE/GE code) with zero-extended readback.
// Optional branch-condition evaluator is built when STATUS_REG_COND_EN is defined.
module status_register (
    input  logic        CLK,
    input  logic        reset,
    input  logic        SRw,
    input  logic        Reg2_in,
    input  logic        isZero,
    output logic [15:0] Reg2_out
`ifdef STATUS_REG_COND_EN
    ,
    input  logic [2:0]  cond,
    output logic        cond_true
`endif
);

    // Code layout: bit1 = GE, bit0 = NE; zero dominates an inconsistent sign bit.
    function automatic logic [1:0] encode_status(input logic neg, input logic zero);
        encode_status = {(~neg) | zero, ~zero};
    endfunction

    logic [1:0] status_r;
    logic [1:0] next_status_s;

    // Next-code encoding from the compare outcome.
    always_comb begin
        next_status_s = 2'b00;
        next_status_s = encode_status(Reg2_in, isZero);
    end

    // Status capture; reset is asynchronous and dominates the write enable.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            status_r <= 2'b00;
        end else if (SRw) begin
            status_r <= next_status_s;
        end else begin
            status_r <= status_r;
        end
    end

    assign Reg2_out = {14'b0, status_r};

`ifdef STATUS_REG_COND_EN
    // Only code 00 (no valid compare) is excluded from every non-ALWAYS condition.
    function automatic logic eval_cond(input logic [2:0] sel, input logic [1:0] code);
        logic result;
        result = 1'b0;
        case (sel)
            3'b000:  result = (code == 2'b10);
            3'b001:  result = (code == 2'b01) || (code == 2'b11);
            3'b010:  result = (code == 2'b01);
            3'b011:  result = (code == 2'b10) || (code == 2'b11);
            3'b100:  result = (code == 2'b11);
            3'b101:  result = (code == 2'b01) || (code == 2'b10);
            3'b110:  result = 1'b1;
            3'b111:  result = (code != 2'b00);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

    logic cond_true_s;

    // Combinational condition evaluation against the stored code.
    always_comb begin
        cond_true_s = 1'b0;
        cond_true_s = eval_cond(cond, status_r);
    end

    assign cond_true = cond_true_s;
`endif

endmodule

// File: tb/tb_status_register.sv
// Scoreboard bench for status_register: stimulus queues expected values, a
// negedge monitor pops and compares. Condition checks apply with STATUS_REG_COND_EN.
module tb_status_register;

    logic        CLK;
    logic        reset;
    logic        SRw;
    logic        Reg2_in;
    logic        isZero;
    logic [15:0] Reg2_out;
`ifdef STATUS_REG_COND_EN
    logic [2:0]  cond;
    logic        cond_true;
`endif

    status_register dut (
        .CLK      (CLK),
        .reset    (reset),
        .SRw      (SRw),
        .Reg2_in  (Reg2_in),
        .isZero   (isZero),
        .Reg2_out (Reg2_out)
`ifdef STATUS_REG_COND_EN
        ,
        .cond     (cond),
        .cond_true(cond_true)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] exp_out;
        logic        chk_ct;
        logic        exp_ct;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: compare one queued expectation per falling edge.
    initial begin
        exp_t item;
        forever begin
            @(negedge CLK);
            if (sb_q.size() > 0) begin
                item = sb_q.pop_front();
                n_vec++;
                if (Reg2_out !== item.exp_out) begin
                    n_err++;
                    $display("FAIL %s: Reg2_out got %h expected %h", item.name, Reg2_out, item.exp_out);
                end
`ifdef STATUS_REG_COND_EN
                if (item.chk_ct) begin
                    n_vec++;
                    if (cond_true !== item.exp_ct) begin
                        n_err++;
                        $display("FAIL %s: cond_true got %b expected %b (cond=%b)",
                                 item.name, cond_true, item.exp_ct, cond);
                    end
                end
`endif
            end
        end
    end

    task automatic push(input string name, input logic [15:0] exp_out,
                        input logic chk_ct, input logic exp_ct);
        exp_t e;
        e.name    = name;
        e.exp_out = exp_out;
        e.chk_ct  = chk_ct;
        e.exp_ct  = exp_ct;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 4) begin
            @(posedge CLK);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: monitor timeout, %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // One cycle: drive inputs, take a rising edge, queue the expected response.
    task automatic step(input string name, input logic srw, input logic neg, input logic zero,
                        input logic [2:0] c, input logic [15:0] exp_out, input logic exp_ct);
        @(negedge CLK);
        #1;
        SRw     = srw;
        Reg2_in = neg;
        isZero  = zero;
`ifdef STATUS_REG_COND_EN
        cond    = c;
`endif
        @(posedge CLK);
        #1;
        push(name, exp_out, 1'b1, exp_ct);
        drain(name);
    endtask

    initial begin
        reset   = 1'b0;
        SRw     = 1'b1;
        Reg2_in = 1'b0;
        isZero  = 1'b0;
`ifdef STATUS_REG_COND_EN
        cond    = 3'b000;
`endif
        step("rst_hold_eq", 1'b1, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0);
        step("rst_hold_always", 1'b1, 1'b1, 1'b0, 3'b110, 16'h0000, 1'b1);

        @(negedge CLK);
        reset = 1'b1;

        step("lt_load", 1'b1, 1'b1, 1'b0, 3'b010, 16'h0001, 1'b1);
        step("lt_ge", 1'b0, 1'b1, 1'b0, 3'b011, 16'h0001, 1'b0);

        step("gt_load", 1'b1, 1'b0, 1'b0, 3'b100, 16'h0003, 1'b1);
        step("gt_ge", 1'b0, 1'b0, 1'b0, 3'b011, 16'h0003, 1'b1);
        step("gt_ne", 1'b0, 1'b0, 1'b0, 3'b001, 16'h0003, 1'b1);
        step("gt_valid", 1'b0, 1'b0, 1'b0, 3'b111, 16'h0003, 1'b1);
        step("gt_eq", 1'b0, 1'b0, 1'b0, 3'b000, 16'h0003, 1'b0);
        step("gt_lt", 1'b0, 1'b0, 1'b0, 3'b010, 16'h0003, 1'b0);
        step("gt_le", 1'b0, 1'b0, 1'b0, 3'b101, 16'h0003, 1'b0);

        step("eq_load", 1'b1, 1'b0, 1'b1, 3'b000, 16'h0002, 1'b1);
        step("eq_zero_wins", 1'b1, 1'b1, 1'b1, 3'b011, 16'h0002, 1'b1);
        step("eq_le", 1'b0, 1'b1, 1'b1, 3'b101, 16'h0002, 1'b1);
        step("eq_ne", 1'b0, 1'b1, 1'b1, 3'b001, 16'h0002, 1'b0);
        step("eq_gt", 1'b0, 1'b1, 1'b1, 3'b100, 16'h0002, 1'b0);

        step("hold_load", 1'b1, 1'b0, 1'b0, 3'b100, 16'h0003, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 1'b1, 1'b0, 3'b010, 16'h0003, 1'b0);
        end

        // Asynchronous reset asserted mid-cycle from a loaded LT code.
        step("pre_rst_lt", 1'b1, 1'b1, 1'b0, 3'b110, 16'h0001, 1'b1);
        @(posedge CLK);
        #2;
        SRw     = 1'b1;
        Reg2_in = 1'b0;
        isZero  = 1'b0;
        reset   = 1'b0;
        push("rst_async", 16'h0000, 1'b1, 1'b1);
        drain("rst_async");
        step("rst_edge1", 1'b1, 1'b0, 1'b0, 3'b110, 16'h0000, 1'b1);
        step("rst_edge2", 1'b1, 1'b0, 1'b0, 3'b111, 16'h0000, 1'b0);
        @(negedge CLK);
        #1;
        SRw   = 1'b0;
        reset = 1'b1;
        push("rst_release", 16'h0000, 1'b0, 1'b0);
        drain("rst_release");

        for (int c = 0; c < 8; c++) begin
            step("post_rst_sweep", 1'b0, 1'b0, 1'b0, 3'(c), 16'h0000, (c == 6) ? 1'b1 : 1'b0);
        end

        step("first_load_after_rst", 1'b1, 1'b1, 1'b1, 3'b000, 16'h0002, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
